// File: rtl/mul_sequencer_pkg.sv
// Shared types and encodings for the multi-cycle multiply sequencer.
package mul_sequencer_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0] FW_NONE = 2'b00;
  localparam logic [1:0] FW_NZ   = 2'b10;
  localparam logic [1:0] FW_CV   = 2'b01;
  localparam logic [1:0] FW_ALL  = 2'b11;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Multiplies only ever touch N and Z; C and V pass through from the current flags.
  function automatic logic [3:0] nz_flags(input logic [31:0] r, input logic [3:0] cur);
    logic [3:0] f;
    f = cur;
    f[FLAG_N] = r[31];
    f[FLAG_Z] = (r == 32'd0);
    return f;
  endfunction

endpackage

// File: rtl/mul_sequencer_if.sv
// Execute-stage handshake between the core pipeline and the multiply sequencer.
interface mul_sequencer_if;
  logic        StartE;
  logic        AccE;
  logic        SetFlagsE;
  logic [31:0] SrcAE;
  logic [31:0] SrcBE;
  logic [31:0] AccSrcE;
  logic [3:0]  FlagsE2;
  logic        FlushE;
  logic        StallMulE;
  logic        MulDoneE;
  logic [31:0] MulResultE;
  logic [3:0]  MulFlags;
  logic [1:0]  MulFlagWrite;

  modport master (
    output StartE, AccE, SetFlagsE, SrcAE, SrcBE, AccSrcE, FlagsE2, FlushE,
    input  StallMulE, MulDoneE, MulResultE, MulFlags, MulFlagWrite
  );

  modport slave (
    input  StartE, AccE, SetFlagsE, SrcAE, SrcBE, AccSrcE, FlagsE2, FlushE,
    output StallMulE, MulDoneE, MulResultE, MulFlags, MulFlagWrite
  );
endinterface

// File: rtl/mul_sequencer_datapath.sv
// Radix-2 shift-add multiply datapath: accumulator, shifting operands and iteration count.
module mul_datapath (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        step,
  input  logic        clear,
  input  logic        acc_en,
  input  logic [31:0] mcand_in,
  input  logic [31:0] mplier_in,
  input  logic [31:0] acc_in,
  output logic [31:0] acc,
  output logic        mplier_zero,
  output logic        last
);

  logic [31:0] mcand;
  logic [31:0] mplier;
  logic [4:0]  count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
    end else if (load) begin
      acc    <= acc_en ? acc_in : 32'd0;
      mcand  <= mcand_in;
      mplier <= mplier_in;
      count  <= '0;
    end else if (step) begin
      acc    <= mplier[0] ? (acc + mcand) : acc;
      mcand  <= {mcand[30:0], 1'b0};
      mplier <= {1'b0, mplier[31:1]};
      count  <= count + 5'd1;
    end
  end

  // Looks ahead at the multiplier as it will be after this step's shift.
  assign mplier_zero = (mplier[31:1] == 31'd0);
  assign last        = (count == 5'd31);

endmodule

// File: rtl/mul_sequencer.sv
// MUL/MLA sequencer: stalls the front end while the datapath iterates, then pulses done.
//   state  | meaning
//   S_IDLE | waiting for a condition-passed MUL/MLA
//   S_BUSY | one shift-add iteration per cycle, pipeline held
//   S_DONE | result and NZ update presented for one cycle
module mul_sequencer
  import mul_sequencer_pkg::*;
#(
  parameter bit EARLY_TERM = 1'b1
) (
  input logic           clk,
  input logic           reset,
  mul_sequencer_if.slave bus
);

  state_t      state, state_nxt;
  logic        load, step;
  logic        stall, done;
  logic [1:0]  flag_write;
  logic [31:0] acc;
  logic        mplier_zero, last;

  mul_datapath u_datapath (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .step        (step),
    .clear       (bus.FlushE),
    .acc_en      (bus.AccE),
    .mcand_in    (bus.SrcAE),
    .mplier_in   (bus.SrcBE),
    .acc_in      (bus.AccSrcE),
    .acc         (acc),
    .mplier_zero (mplier_zero),
    .last        (last)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // A flush outranks everything: no stall, no done, back to idle.
  always_comb begin
    state_nxt  = state;
    load       = 1'b0;
    step       = 1'b0;
    stall      = 1'b0;
    done       = 1'b0;
    flag_write = FW_NONE;
    if (bus.FlushE) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.StartE) begin
            load      = 1'b1;
            stall     = 1'b1;
            state_nxt = S_BUSY;
          end
        end
        S_BUSY: begin
          step  = 1'b1;
          stall = 1'b1;
          if (last || (EARLY_TERM && mplier_zero)) state_nxt = S_DONE;
        end
        S_DONE: begin
          done      = 1'b1;
          state_nxt = S_IDLE;
          if (bus.SetFlagsE) flag_write = FW_NZ;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  assign bus.StallMulE    = stall;
  assign bus.MulDoneE     = done;
  assign bus.MulResultE   = done ? acc : 32'd0;
  assign bus.MulFlags     = nz_flags(acc, bus.FlagsE2);
  assign bus.MulFlagWrite = flag_write;

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed bench for mul_sequencer, exercising both early-terminate and fixed-length builds.
module tb_mul_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        sel = 1'b0;
  logic        start = 1'b0;
  logic        accv = 1'b0;
  logic        sflag = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] a = '0, b = '0, accsrc = '0;
  logic [3:0]  fl = '0;

  mul_sequencer_if if0 ();
  mul_sequencer_if if1 ();

  assign if0.StartE = start & ~sel;
  assign if1.StartE = start & sel;
  assign if0.AccE = accv;        assign if1.AccE = accv;
  assign if0.SetFlagsE = sflag;  assign if1.SetFlagsE = sflag;
  assign if0.SrcAE = a;          assign if1.SrcAE = a;
  assign if0.SrcBE = b;          assign if1.SrcBE = b;
  assign if0.AccSrcE = accsrc;   assign if1.AccSrcE = accsrc;
  assign if0.FlagsE2 = fl;       assign if1.FlagsE2 = fl;
  assign if0.FlushE = flush;     assign if1.FlushE = flush;

  mul_sequencer #(.EARLY_TERM(1'b0)) u_fixed (.clk(clk), .reset(reset), .bus(if0));
  mul_sequencer #(.EARLY_TERM(1'b1)) u_early (.clk(clk), .reset(reset), .bus(if1));

  logic        stall, done;
  logic [31:0] res;
  logic [3:0]  mflags;
  logic [1:0]  mfw;
  assign stall  = sel ? if1.StallMulE    : if0.StallMulE;
  assign done   = sel ? if1.MulDoneE     : if0.MulDoneE;
  assign res    = sel ? if1.MulResultE   : if0.MulResultE;
  assign mflags = sel ? if1.MulFlags     : if0.MulFlags;
  assign mfw    = sel ? if1.MulFlagWrite : if0.MulFlagWrite;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int bitlen(input logic [31:0] v);
    int n = 0;
    for (int i = 0; i < 32; i++) if (v[i]) n = i + 1;
    return n;
  endfunction

  // Cycle (counting the start cycle as 0) in which done is expected.
  function automatic int latency(input bit et, input logic [31:0] m);
    int l;
    if (!et) return 33;
    l = bitlen(m);
    return 1 + ((l > 1) ? l : 1);
  endfunction

  function automatic logic [31:0] product(input logic [31:0] x, input logic [31:0] y,
                                          input logic use_acc, input logic [31:0] z);
    logic [63:0] p;
    p = {32'd0, x} * {32'd0, y};
    return p[31:0] + (use_acc ? z : 32'd0);
  endfunction

  // Reference model: tracks one outstanding multiply in cycle terms.
  bit          m_valid = 0, m_active = 0, m_just_reset = 0;
  int          m_cyc = 0, m_lat = 0;
  logic [31:0] m_res = '0;
  logic        e_stall, e_done;

  always @(negedge clk) begin
    if (m_valid) begin
      if (!m_active) begin
        e_stall = start & ~flush & ~reset;
        e_done  = 1'b0;
        if (reset) e_stall = stall;
      end else begin
        e_stall = ~flush & (m_cyc < m_lat);
        e_done  = ~flush & (m_cyc == m_lat);
      end
      chk("model_stall", {31'd0, stall}, {31'd0, e_stall});
      chk("model_done", {31'd0, done}, {31'd0, e_done});
      if (e_done) begin
        chk("model_result", res, m_res);
        chk("model_flags", {28'd0, mflags}, {28'd0, m_res[31], (m_res == 32'd0), fl[1:0]});
        chk("model_flagwrite", {30'd0, mfw}, sflag ? 32'd2 : 32'd0);
      end else begin
        chk("model_flagwrite_quiet", {30'd0, mfw}, 32'd0);
      end
      if (m_just_reset) chk("model_result_after_reset", res, 32'd0);
    end
    m_just_reset = 0;
    if (reset) begin
      m_valid      = 1;
      m_active     = 0;
      m_just_reset = 1;
    end else if (!m_active) begin
      if (start && !flush) begin
        m_active = 1;
        m_cyc    = 1;
        m_lat    = latency(sel, b);
        m_res    = product(a, b, accv, accsrc);
      end
    end else if (flush || m_cyc == m_lat) begin
      m_active = 0;
    end else begin
      m_cyc++;
    end
  end

  task automatic do_op(input string name, input bit s_sel, input bit s_acc, input bit s_s,
                       input logic [31:0] sa, input logic [31:0] sb, input logic [31:0] sacc,
                       input logic [3:0] sfl, input logic [31:0] x_res, input int x_lat,
                       input logic [3:0] x_flags, input logic [1:0] x_fw);
    int  k = 0;
    bit  seen = 0;
    @(posedge clk); #1;
    sel = s_sel; accv = s_acc; sflag = s_s; a = sa; b = sb; accsrc = sacc; fl = sfl;
    flush = 1'b0; start = 1'b1;
    while (!seen && k <= 40) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        chk({name, "_latency"}, k, x_lat);
        chk({name, "_result"}, res, x_res);
        chk({name, "_flags"}, {28'd0, mflags}, {28'd0, x_flags});
        chk({name, "_flagwrite"}, {30'd0, mfw}, {30'd0, x_fw});
      end else begin
        k++;
      end
    end
    if (!seen) chk({name, "_done_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic go_idle();
    @(posedge clk); #1;
    start = 1'b0;
    flush = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_stall", {31'd0, stall}, 32'd0);
    chk("reset_result", res, 32'd0);

    do_op("early_7x6", 1'b1, 1'b0, 1'b1, 32'd7, 32'd6, 32'd0, 4'b0011,
          32'd42, 4, 4'b0011, 2'b10);
    do_op("fixed_ones", 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 4'b0000,
          32'd1, 33, 4'b0000, 2'b00);
    do_op("early_mla_zero", 1'b1, 1'b1, 1'b1, 32'd3, 32'd0, 32'hFFFF_FFFB, 4'b0110,
          32'hFFFF_FFFB, 2, 4'b1010, 2'b10);
    do_op("early_wrap", 1'b1, 1'b0, 1'b1, 32'h0001_0000, 32'h0001_0000, 32'd0, 4'b1001,
          32'd0, 18, 4'b0101, 2'b10);
    do_op("fixed_mla", 1'b0, 1'b1, 1'b1, 32'h1234, 32'h5678, 32'd100, 4'b1111,
          32'd103153860, 33, 4'b0011, 2'b10);
    do_op("early_by_one", 1'b1, 1'b1, 1'b0, 32'd5, 32'd1, 32'd10, 4'b0000,
          32'd15, 2, 4'b0000, 2'b00);
    go_idle();
    repeat (2) @(posedge clk);

    // Flush in cycle 5 of a fixed-length multiply, then a fresh one in cycle 6.
    @(posedge clk); #1;
    sel = 1'b0; accv = 1'b0; sflag = 1'b1; a = 32'd9; b = 32'd9; fl = 4'b0000; start = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(negedge clk);
    chk("flush_stall", {31'd0, stall}, 32'd0);
    chk("flush_done", {31'd0, done}, 32'd0);
    do_op("after_flush_5x5", 1'b0, 1'b0, 1'b0, 32'd5, 32'd5, 32'd0, 4'b0000,
          32'd25, 33, 4'b0000, 2'b00);
    go_idle();
    repeat (2) @(posedge clk);

    // Reset while busy, then two back-to-back multiplies.
    @(posedge clk); #1;
    sel = 1'b1; accv = 1'b0; sflag = 1'b1; a = 32'h1234_5678; b = 32'h0000_FFFF; start = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b1;
    start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("mid_reset_stall", {31'd0, stall}, 32'd0);
    chk("mid_reset_done", {31'd0, done}, 32'd0);
    chk("mid_reset_result", res, 32'd0);
    do_op("b2b_2x3", 1'b1, 1'b0, 1'b1, 32'd2, 32'd3, 32'd0, 4'b0010,
          32'd6, 3, 4'b0010, 2'b10);
    do_op("b2b_4x4", 1'b1, 1'b0, 1'b0, 32'd4, 32'd4, 32'd0, 4'b0000,
          32'd16, 4, 4'b0000, 2'b00);
    go_idle();
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
